// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_queue_pkg;

    localparam int                WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_REQ  = 2'd1,
        FQ_DROP = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } fq_entry_t;

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of {pc, inst} entries; flush overrides push and pop.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fq_entry_t                wr_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fq_entry_t                head
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    fq_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the head is forced to zero while empty so stale
    // words are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_entry;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC owner, imem request FSM and instruction queue.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        inst_ready
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    fq_state_e     state, state_d;
    logic [31:0]   fetch_pc, fetch_pc_d;
    logic [31:0]   req_addr;
    logic          issue;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_push;
    fq_entry_t     head;

    assign pop = inst_ready & ~redirect;

    always_comb begin
        state_d          = state;
        fetch_pc_d       = fetch_pc;
        push             = 1'b0;
        count_after_push = count + CNT_ONE - {{(CW-1){1'b0}}, pop & ~empty};
        unique case (state)
            FQ_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = align_word(redirect_pc);
                    state_d    = FQ_REQ;
                end else if (!full) begin
                    state_d = FQ_REQ;
                end
            end
            FQ_REQ: begin
                // A redirect with ack finishes the transfer, so the word is simply not pushed.
                if (redirect) begin
                    fetch_pc_d = align_word(redirect_pc);
                    state_d    = imem_ack ? FQ_REQ : FQ_DROP;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc + PC_INC;
                    state_d    = (count_after_push < DEPTH_C) ? FQ_REQ : FQ_IDLE;
                end
            end
            FQ_DROP: begin
                if (redirect) fetch_pc_d = align_word(redirect_pc);
                if (imem_ack) state_d = FQ_REQ;
            end
            default: state_d = FQ_IDLE;
        endcase
    end

    // A new address is launched only when no transfer remains outstanding.
    assign issue = (state_d == FQ_REQ) && ((state == FQ_IDLE) || imem_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FQ_IDLE;
            fetch_pc <= align_word(RESET_PC);
            req_addr <= align_word(RESET_PC);
        end else begin
            state    <= state_d;
            fetch_pc <= fetch_pc_d;
            if (issue) req_addr <= fetch_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect),
        .wr_entry ('{pc: fetch_pc, inst: imem_rdata}),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .head     (head)
    );

    assign imem_req   = (state != FQ_IDLE);
    assign imem_addr  = req_addr;
    assign inst_valid = ~empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign inst_pc4   = empty ? '0 : head.pc + PC_INC;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, corner sequences, random stream check.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc, inst_pc4;

    logic        b_req, b_ack, b_valid;
    logic [31:0] b_addr, b_rdata, b_inst, b_pc, b_pc4;

    int   checks   = 0;
    int   failures = 0;
    int   lat      = 0;
    int   wait_cnt = 0;
    logic mem_en   = 1'b1;
    logic force_ack = 1'b0;

    always #5 clk = ~clk;

    // Memory model: acks once a request has been held for `lat` cycles; data is addr^KEY.
    assign imem_ack   = force_ack | (mem_en & imem_req & (wait_cnt >= lat));
    assign imem_rdata = imem_addr ^ KEY;
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    assign b_ack   = b_req;
    assign b_rdata = b_addr ^ KEY;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_pc4(inst_pc4), .inst_ready(inst_ready)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFFFFF8)) dut_b (
        .clk(clk), .reset(reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_rdata(b_rdata), .redirect(1'b0),
        .redirect_pc(32'h0), .inst_valid(b_valid), .inst(b_inst),
        .inst_pc(b_pc), .inst_pc4(b_pc4), .inst_ready(1'b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle after reset.
    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Stream-level reference: consumed PCs run sequentially from the last redirect target.
    logic [31:0] exp_pc;
    logic        sb_on = 1'b0;
    logic        pend;
    logic [31:0] pend_addr;
    int          pops;

    always @(negedge clk) begin
        if (sb_on) begin
            if (imem_req) begin
                check("rand_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                if (pend) check("rand_addr_hold", imem_addr, pend_addr);
            end
            pend      = imem_req && !imem_ack;
            pend_addr = imem_addr;
            if (redirect) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (inst_valid && inst_ready) begin
                check("rand_pc", inst_pc, exp_pc);
                check("rand_inst", inst, exp_pc ^ KEY);
                check("rand_pc4", inst_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        reset       = 1'b1;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset values.
        do_reset();
        @(negedge clk);
        check_bit("rst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_pc4", inst_pc4, 32'h0);
        check_bit("rst_req", imem_req, 1'b0);

        // Streaming with ready=1, then fill-to-full with ready=0 and drain.
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h08});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h10});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h04});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h08});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h0C});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h10});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h14});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h18});
        lat = 0;
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            else            tick();
            inst_ready = tbl[i].ready;
            @(negedge clk);
            check_bit($sformatf("vec%0d_valid", i), inst_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("vec%0d_pc", i), inst_pc, tbl[i].epc);
                check($sformatf("vec%0d_inst", i), inst, tbl[i].epc ^ KEY);
                check($sformatf("vec%0d_pc4", i), inst_pc4, tbl[i].epc + 32'd4);
            end
            check_bit($sformatf("vec%0d_req", i), imem_req, tbl[i].ereq);
            if (tbl[i].ereq) check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].eaddr);
        end

        // PC wrap on the instance reset to FFFFFFF8.
        do_reset();
        tick();
        tick();
        @(negedge clk);
        check("wrap_pc0", b_pc, 32'hFFFFFFF8);
        check("wrap_inst0", b_inst, 32'hFFFFFFF8 ^ KEY);
        tick();
        @(negedge clk);
        check("wrap_pc1", b_pc, 32'hFFFFFFFC);
        check("wrap_pc4_1", b_pc4, 32'h0);
        tick();
        @(negedge clk);
        check("wrap_pc2", b_pc, 32'h0);
        check("wrap_pc4_2", b_pc4, 32'h4);

        // Redirect while a slow request is outstanding.
        lat = 3;
        inst_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        check_bit("t3_req8_seen", found, 1'b1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        check("t3_addr_redirect_cycle", imem_addr, 32'h8);
        tick();
        redirect = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_addr_hold", imem_addr, 32'h8);
            check_bit("t3_req_hold", imem_req, 1'b1);
            if (imem_ack) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_bit("t3_ack_seen", found, 1'b1);
        tick();
        @(negedge clk);
        check_bit("t3_new_req", imem_req, 1'b1);
        check("t3_new_addr", imem_addr, 32'h100);
        for (int k = 0; k < 20; k++) begin
            if (inst_valid) break;
            tick();
            @(negedge clk);
        end
        check_bit("t3_valid", inst_valid, 1'b1);
        check("t3_first_pc", inst_pc, 32'h100);
        check("t3_first_inst", inst, 32'h100 ^ KEY);

        // Redirect coinciding with ack and pop while the queue holds two entries.
        lat = 0;
        inst_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        check_bit("t4_req8_seen", found, 1'b1);
        check_bit("t4_ack", imem_ack, 1'b1);
        check("t4_head_pc", inst_pc, 32'h0);
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check_bit("t4_flushed", inst_valid, 1'b0);
        check("t4_new_addr", imem_addr, 32'h200);
        tick();
        @(negedge clk);
        check_bit("t4_valid", inst_valid, 1'b1);
        check("t4_pc", inst_pc, 32'h200);

        // Reset during an outstanding request; the late ack must be ignored.
        lat = 3;
        inst_ready = 1'b1;
        do_reset();
        tick();
        @(negedge clk);
        check_bit("t6_req_before", imem_req, 1'b1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        check_bit("t6_req_idle", imem_req, 1'b0);
        check_bit("t6_valid_ack", inst_valid, 1'b0);
        tick();
        force_ack = 1'b0;
        @(negedge clk);
        check_bit("t6_no_push", inst_valid, 1'b0);
        check_bit("t6_req", imem_req, 1'b1);
        check("t6_addr", imem_addr, 32'h0);

        // Randomised traffic against the stream reference.
        lat = 1;
        inst_ready = 1'b0;
        do_reset();
        exp_pc = 32'h0;
        pend   = 1'b0;
        pops   = 0;
        sb_on  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) lat = int'($urandom_range(0, 3));
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            tick();
        end
        redirect = 1'b0;
        @(negedge clk);
        sb_on = 1'b0;
        check_bit("rand_progress", pops > 200, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
